// File: rtl/redun_mont_pkg.sv
// Constants and shared helpers for the MSU squaring kernel and its host stream bridge.
package redun_mont_pkg;

   localparam int          DAT_BITS   = 128;
   localparam int          TOT_BITS   = 144;
   localparam logic [15:0] BUILD_SEED = 16'hA5C3;

   typedef enum logic [1:0] {
      H_IDLE,
      H_SEND,
      H_RECV,
      H_DONE
   } host_state_t;

   // Job frame: t_start, t_final, sq_in packed LSB-first, rounded up to whole words.
   function automatic int in_count(input int t_len, input int sq_in_bits, input int axi_len);
      return (2 * t_len + sq_in_bits + axi_len - 1) / axi_len;
   endfunction

   // Result frame: t_current, 16-bit seed, redundant sq_out.
   function automatic int out_count(input int t_len, input int sq_out_bits, input int axi_len);
      return (16 + t_len + sq_out_bits + axi_len - 1) / axi_len;
   endfunction

endpackage

// File: rtl/msu_host_axis_if.sv
// AXI-stream channel; master drives payload, slave drives tready.
interface msu_host_axis_if #(
   parameter int AXI_LEN = 32
);
   logic                   tvalid;
   logic                   tready;
   logic [AXI_LEN-1:0]     tdata;
   logic [AXI_LEN/8-1:0]   tkeep;
   logic                   tlast;

   modport master (output tvalid, tdata, tkeep, tlast, input tready);
   modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_word_ser.sv
// Load-and-shift serializer: emits N words of W bits LSB-first with tlast on the final word.
module axis_word_ser #(
   parameter int W = 32,
   parameter int N = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [N*W-1:0] load_data,
   input  logic           ready,
   output logic           valid,
   output logic [W-1:0]   data,
   output logic           last,
   output logic           done
);
   localparam int CW = $clog2(N + 1);

   logic [N*W-1:0] sh;
   logic [CW-1:0]  cnt;
   logic           act;

   // Zero fill on shift leaves the register cleared once the frame has gone out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sh  <= '0;
         cnt <= '0;
         act <= 1'b0;
      end else if (load) begin
         sh  <= load_data;
         cnt <= '0;
         act <= 1'b1;
      end else if (act && ready) begin
         sh  <= sh >> W;
         cnt <= cnt + 1'b1;
         if (cnt == CW'(N - 1))
            act <= 1'b0;
      end
   end

   assign valid = act;
   assign data  = sh[W-1:0];
   assign last  = act && (cnt == CW'(N - 1));
   assign done  = act && ready && last;

endmodule

// File: rtl/msu_host_axis.sv
// Host-side job serializer / result deserializer for the MSU kernel stream pair.
// Optional: define MSU_HOST_SEED_CHECK_EN to flag seed mismatches in res_err[1].
module msu_host_axis
   import redun_mont_pkg::*;
#(
   parameter int AXI_LEN     = 32,
   parameter int T_LEN       = 64,
   parameter int SQ_IN_BITS  = DAT_BITS,
   parameter int SQ_OUT_BITS = TOT_BITS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   job_valid,
   output logic                   job_ready,
   input  logic [T_LEN-1:0]       job_t_start,
   input  logic [T_LEN-1:0]       job_t_final,
   input  logic [SQ_IN_BITS-1:0]  job_sq_in,
   msu_host_axis_if.master        m_axis,
   msu_host_axis_if.slave         s_axis,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [T_LEN-1:0]       res_t_current,
   output logic [15:0]            res_seed,
   output logic [SQ_OUT_BITS-1:0] res_sq_out,
   output logic [1:0]             res_err,
   output logic                   busy
);
   localparam int IN_COUNT  = in_count(T_LEN, SQ_IN_BITS, AXI_LEN);
   localparam int OUT_COUNT = out_count(T_LEN, SQ_OUT_BITS, AXI_LEN);
   localparam int IN_W      = IN_COUNT * AXI_LEN;
   localparam int OUT_W     = OUT_COUNT * AXI_LEN;
   localparam int RC_W      = $clog2(OUT_COUNT + 1);

   host_state_t       state, state_nxt;
   logic              job_hs, tx_done;
   logic              rx_hs, rx_last_cnt, rx_end, seed_bad;
   logic [IN_W-1:0]   tx_load;
   logic [OUT_W-1:0]  rx_reg, rx_nxt;
   logic [RC_W-1:0]   rx_cnt;
   logic              unused_tkeep;

   assign job_ready     = (state == H_IDLE);
   assign busy          = (state != H_IDLE);
   assign res_valid     = (state == H_DONE);
   assign s_axis.tready = (state == H_RECV);
   assign job_hs        = job_valid && job_ready;
   assign tx_load       = IN_W'({job_sq_in, job_t_final, job_t_start});
   assign m_axis.tkeep  = '1;
   assign unused_tkeep  = ^s_axis.tkeep;

   axis_word_ser #(.W(AXI_LEN), .N(IN_COUNT)) u_tx (
      .clk       (clk),
      .rst       (reset),
      .load      (job_hs),
      .load_data (tx_load),
      .ready     (m_axis.tready),
      .valid     (m_axis.tvalid),
      .data      (m_axis.tdata),
      .last      (m_axis.tlast),
      .done      (tx_done)
   );

   // Frame ends on tlast or on the expected word count, whichever comes first.
   assign rx_hs       = s_axis.tvalid && s_axis.tready;
   assign rx_last_cnt = (rx_cnt == RC_W'(OUT_COUNT - 1));
   assign rx_end      = rx_hs && (s_axis.tlast || rx_last_cnt);
   assign rx_nxt      = {s_axis.tdata, rx_reg[OUT_W-1:AXI_LEN]};

`ifdef MSU_HOST_SEED_CHECK_EN
   assign seed_bad = (rx_nxt[T_LEN +: 16] != (rx_nxt[15:0] ^ BUILD_SEED));
`else
   assign seed_bad = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= H_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         H_IDLE:  if (job_hs)    state_nxt = H_SEND;
         H_SEND:  if (tx_done)   state_nxt = H_RECV;
         H_RECV:  if (rx_end)    state_nxt = H_DONE;
         H_DONE:  if (res_ready) state_nxt = H_IDLE;
         default:                state_nxt = H_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_reg        <= '0;
         rx_cnt        <= '0;
         res_t_current <= '0;
         res_seed      <= '0;
         res_sq_out    <= '0;
         res_err       <= '0;
      end else begin
         if (state == H_SEND && tx_done) begin
            rx_cnt <= '0;
         end else if (rx_hs) begin
            rx_reg <= rx_nxt;
            rx_cnt <= rx_cnt + 1'b1;
         end
         // Capture straight from the incoming beat so DONE follows the last handshake directly.
         if (state == H_RECV && rx_end) begin
            res_t_current <= rx_nxt[T_LEN-1:0];
            res_seed      <= rx_nxt[T_LEN +: 16];
            res_sq_out    <= rx_nxt[T_LEN+16 +: SQ_OUT_BITS];
            res_err       <= {seed_bad, (s_axis.tlast != rx_last_cnt)};
         end
      end
   end

endmodule
